// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller: state encoding, default sizing
// and the datapath mux-select encodings.
package gcd_pkg;

    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned MAX_ITER_DEF = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CMP    = 3'd3,
        S_SUB_A  = 3'd4,
        S_SUB_B  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // Subtractor operand selects and bus source select.
    localparam logic SEL_A      = 1'b0;
    localparam logic SEL_B      = 1'b1;
    localparam logic SELIN_DATA = 1'b1;
    localparam logic SELIN_SUB  = 1'b0;

endpackage

// File: rtl/gcd_iter_counter.sv
// Subtraction-step counter: synchronous clear, increment, saturating at all-ones.
module gcd_iter_counter
    import gcd_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             incr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for a subtractive GCD datapath; outputs are Moore-decoded from
// the state, and an iteration limit turns non-terminating operands into ERR.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int unsigned MAX_ITER = MAX_ITER_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    output logic             lda,
    output logic             ldb,
    output logic             sel1,
    output logic             sel2,
    output logic             selin,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_count
);

    localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

    state_t state;
    state_t state_next;
    logic   start_ok;
    logic   cnt_clear;
    logic   cnt_incr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        lda        = 1'b0;
        ldb        = 1'b0;
        sel1       = SEL_A;
        sel2       = SEL_A;
        selin      = SELIN_SUB;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state)
            S_IDLE: begin
                start_ok = 1'b1;
            end
            S_LOAD_A: begin
                busy       = 1'b1;
                selin      = SELIN_DATA;
                lda        = 1'b1;
                state_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                busy       = 1'b1;
                selin      = SELIN_DATA;
                ldb        = 1'b1;
                state_next = S_CMP;
            end
            S_CMP: begin
                busy = 1'b1;
                // Equality wins even on the last permitted step.
                if (eq) begin
                    state_next = S_DONE;
                end else if (iter_count == ITER_LIMIT) begin
                    state_next = S_ERR;
                end else if (gt) begin
                    state_next = S_SUB_A;
                end else if (lt) begin
                    state_next = S_SUB_B;
                end else begin
                    state_next = S_ERR;
                end
            end
            S_SUB_A: begin
                busy       = 1'b1;
                sel1       = SEL_A;
                sel2       = SEL_B;
                selin      = SELIN_SUB;
                lda        = 1'b1;
                state_next = S_CMP;
            end
            S_SUB_B: begin
                busy       = 1'b1;
                sel1       = SEL_B;
                sel2       = SEL_A;
                selin      = SELIN_SUB;
                ldb        = 1'b1;
                state_next = S_CMP;
            end
            S_DONE: begin
                done     = 1'b1;
                start_ok = 1'b1;
            end
            S_ERR: begin
                done     = 1'b1;
                err      = 1'b1;
                start_ok = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (start_ok && start) begin
            state_next = S_LOAD_A;
        end
        // Abort overrides any start request or in-flight transition.
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    assign cnt_clear = start_ok && start && !abort;
    assign cnt_incr  = (state == S_SUB_A) || (state == S_SUB_B);

    gcd_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .incr  (cnt_incr),
        .count (iter_count)
    );

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: a behavioural GCD datapath closes the loop,
// table-driven operand vectors plus directed repulse/reset/abort sequences.
module tb_gcd_controller;

    localparam int CNT_W    = 16;
    localparam int MAX_ITER = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             lt, gt, eq;
    logic             lda, ldb, sel1, sel2, selin;
    logic             busy, done, err;
    logic [CNT_W-1:0] iter_count;

    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [15:0] dp_a = '0;
    logic [15:0] dp_b = '0;
    logic [15:0] data_in, sub_out, bus;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gcd_controller #(
        .MAX_ITER (MAX_ITER),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .lt         (lt),
        .gt         (gt),
        .eq         (eq),
        .lda        (lda),
        .ldb        (ldb),
        .sel1       (sel1),
        .sel2       (sel2),
        .selin      (selin),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .iter_count (iter_count)
    );

    // Behavioural datapath: two registers, a subtractor with operand muxes, bus mux.
    assign data_in = ldb ? op_b : op_a;
    assign sub_out = (sel1 ? dp_b : dp_a) - (sel2 ? dp_b : dp_a);
    assign bus     = selin ? data_in : sub_out;
    assign lt      = dp_a < dp_b;
    assign gt      = dp_a > dp_b;
    assign eq      = dp_a == dp_b;

    always @(posedge clk) begin
        if (lda) dp_a <= bus;
        if (ldb) dp_b <= bus;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        int          iters;
        int          lat;
        logic        is_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input bit repulse, output int lat);
        bit pulsed;
        pulsed = 1'b0;
        op_a = a;
        op_b = b;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (repulse && !pulsed && lda && !selin) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_lda"}, lda, 0);
        check({tag, "_ldb"}, ldb, 0);
        check({tag, "_selin"}, selin, 0);
    endtask

    initial begin
        int lat;
        int guard;
        int cmps;

        vecs[0]  = '{16'd48, 16'd18, 16'd6, 4, 11, 1'b0};
        vecs[1]  = '{16'd7,  16'd7,  16'd7, 0, 3,  1'b0};
        vecs[2]  = '{16'd0,  16'd5,  16'd0, 8, 19, 1'b1};
        vecs[3]  = '{16'd9,  16'd6,  16'd3, 2, 7,  1'b0};
        vecs[4]  = '{16'd12, 16'd8,  16'd4, 2, 7,  1'b0};
        vecs[5]  = '{16'd5,  16'd0,  16'd0, 8, 19, 1'b1};
        vecs[6]  = '{16'd9,  16'd1,  16'd1, 8, 19, 1'b0};
        vecs[7]  = '{16'd10, 16'd1,  16'd0, 8, 19, 1'b1};
        vecs[8]  = '{16'd0,  16'd0,  16'd0, 0, 3,  1'b0};
        vecs[9]  = '{16'd15, 16'd5,  16'd5, 2, 7,  1'b0};
        vecs[10] = '{16'd8,  16'd1,  16'd1, 7, 17, 1'b0};
        vecs[11] = '{16'd1,  16'd2,  16'd1, 1, 5,  1'b0};

        #1;
        check_quiet("reset");
        check("reset_iter", iter_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("idle");

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, lat);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_done", i), done, 1);
            check($sformatf("v%0d_err", i), err, vecs[i].is_err);
            check($sformatf("v%0d_iter", i), iter_count, vecs[i].iters);
            if (!vecs[i].is_err) check($sformatf("v%0d_res", i), dp_a, vecs[i].res);
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_hold_done", i), done, 1);
            check($sformatf("v%0d_hold_err", i), err, vecs[i].is_err);
        end

        // Start re-pulsed while in SUB_A must be ignored.
        run_op(16'd48, 16'd18, 1'b1, lat);
        check("repulse_lat", lat, 11);
        check("repulse_res", dp_a, 6);
        check("repulse_iter", iter_count, 4);
        check("repulse_err", err, 0);

        // Asynchronous reset in the second CMP visit.
        op_a = 16'd48;
        op_b = 16'd18;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        cmps  = 0;
        while (guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
            if (busy && !lda && !ldb) begin
                cmps++;
                if (cmps == 2) break;
            end
        end
        check("rst_cmp_found", cmps, 2);
        check("rst_iter_before", iter_count, 1);
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid");
        check("rst_mid_iter", iter_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("rst_wait");
        run_op(16'd9, 16'd6, 1'b0, lat);
        check("after_rst_lat", lat, 7);
        check("after_rst_res", dp_a, 3);
        check("after_rst_iter", iter_count, 2);

        // Abort from DONE clears done.
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_done_done", done, 0);
        check("abort_done_busy", busy, 0);

        // Abort while in SUB_B.
        op_a = 16'd48;
        op_b = 16'd18;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!(ldb && !selin) && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("subb_found", ldb && !selin, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_quiet("abort_subb");
        repeat (3) @(posedge clk);
        #1;
        check_quiet("abort_stay");

        run_op(16'd7, 16'd7, 1'b0, lat);
        check("pre_done_lat", lat, 3);
        run_op(16'd12, 16'd8, 1'b0, lat);
        check("from_done_lat", lat, 7);
        check("from_done_res", dp_a, 4);
        check("from_done_iter", iter_count, 2);
        check("from_done_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
